// File: rtl/branch_ctrl.sv
// Branch resolution stage feeding the PC block: decodes branches at the
// current PC and evaluates them against the registered ALU flags. A taken
// branch issues a one-cycle offset pulse, and the shadow fetch behind it is
// squashed.
module branch_ctrl #(
  parameter int unsigned LUT_DEPTH = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         CLK,
  input  logic                         init,
  input  logic                         halt,
  input  logic [8:0]                   inst,
  input  logic                         flag_we,
  input  logic                         flag_z,
  input  logic                         flag_n,
  input  logic                         lut_we,
  input  logic [$clog2(LUT_DEPTH)-1:0] lut_addr,
  input  logic [8:0]                   lut_wdata,
  output logic                         branch_en,
  output logic                         bSIGN,
  output logic [7:0]                   bOFFSET,
  output logic                         squash,
  output logic [CNT_W-1:0]             taken_cnt
);

  localparam int unsigned IDX_W = $clog2(LUT_DEPTH);
  localparam int unsigned ENT_W = 9;
  localparam int unsigned OFF_W = 8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SHADOW = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               branch_en_q, branch_en_d;
  logic               bsign_q, bsign_d;
  logic [OFF_W-1:0]   boffset_q, boffset_d;
  logic               squash_q, squash_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               z_q, z_d;
  logic               n_q, n_d;
  logic [ENT_W-1:0]   lut_q [LUT_DEPTH];
  logic [ENT_W-1:0]   lut_d [LUT_DEPTH];

  logic               is_branch;
  logic               cond_ok;
  logic [ENT_W-1:0]   entry;

  // Offset table write port; lookups below read the pre-write contents
  always_comb begin
    lut_d = lut_q;
    if (lut_we) lut_d[lut_addr] = lut_wdata;
  end

  // Branch decode and condition evaluation against registered flags
  always_comb begin
    is_branch = (inst[8:6] == 3'b111);
    entry     = lut_q[inst[IDX_W-1:0]];
    case (inst[5:4])
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = z_q;
      2'b10:   cond_ok = ~z_q;
      default: cond_ok = n_q;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    branch_en_d = 1'b0;
    bsign_d     = 1'b0;
    boffset_d   = '0;
    squash_d    = 1'b0;
    cnt_d       = cnt_q;
    z_d         = flag_we ? flag_z : z_q;
    n_d         = flag_we ? flag_n : n_q;

    case (state_q)
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (is_branch && cond_ok) begin
          state_d     = ST_SHADOW;
          branch_en_d = 1'b1;
          squash_d    = 1'b1;
          bsign_d     = entry[8];
          boffset_d   = entry[7:0];
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHADOW: begin
        state_d = halt ? ST_HALTED : ST_RUN;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Control state with synchronous init; init discards same-cycle flag writes
  always_ff @(posedge CLK) begin
    if (init) begin
      state_q     <= ST_RUN;
      branch_en_q <= 1'b0;
      bsign_q     <= 1'b0;
      boffset_q   <= '0;
      squash_q    <= 1'b0;
      cnt_q       <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      branch_en_q <= branch_en_d;
      bsign_q     <= bsign_d;
      boffset_q   <= boffset_d;
      squash_q    <= squash_d;
      cnt_q       <= cnt_d;
      z_q         <= z_d;
      n_q         <= n_d;
    end
  end

  // Offset table storage, deliberately untouched by init
  always_ff @(posedge CLK) begin
    lut_q <= lut_d;
  end

  assign branch_en = branch_en_q;
  assign bSIGN     = bsign_q;
  assign bOFFSET   = boffset_q;
  assign squash    = squash_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl (CNT_W=4 build). The driver applies one
// vector per cycle and queues the hand-computed outputs expected after that
// edge. The monitor pops the queue and compares on every falling edge.
module tb_branch_ctrl;

  localparam int unsigned CW = 4;

  logic          CLK;
  logic          init, halt, flag_we, flag_z, flag_n, lut_we;
  logic [8:0]    inst, lut_wdata;
  logic [3:0]    lut_addr;
  logic          branch_en, bSIGN, squash;
  logic [7:0]    bOFFSET;
  logic [CW-1:0] taken_cnt;

  typedef struct {
    logic       be;
    logic       sg;
    logic [7:0] off;
    logic       sq;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [8:0] NOP   = 9'h000;
  localparam logic [8:0] B_U3  = 9'h1C3; // always, idx 3
  localparam logic [8:0] B_U2  = 9'h1C2; // always, idx 2
  localparam logic [8:0] B_U5  = 9'h1C5; // always, idx 5
  localparam logic [8:0] B_Z1  = 9'h1D1; // if Z,  idx 1
  localparam logic [8:0] B_NZ1 = 9'h1E1; // if !Z, idx 1
  localparam logic [8:0] B_N4  = 9'h1F4; // if N,  idx 4

  branch_ctrl #(.LUT_DEPTH(16), .CNT_W(CW)) dut (
    .CLK(CLK), .init(init), .halt(halt), .inst(inst),
    .flag_we(flag_we), .flag_z(flag_z), .flag_n(flag_n),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .branch_en(branch_en), .bSIGN(bSIGN), .bOFFSET(bOFFSET),
    .squash(squash), .taken_cnt(taken_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One vector per cycle; expected outputs are queued once the edge has passed
  task automatic cyc(input logic i_init, input logic i_halt, input logic [8:0] i_inst,
                     input logic i_fwe, input logic i_fz, input logic i_fn,
                     input logic i_lwe, input logic [3:0] i_la, input logic [8:0] i_lwd,
                     input logic e_be, input logic e_sg, input logic [7:0] e_off,
                     input logic e_sq, input logic [3:0] e_cnt);
    exp_t e;
    init = i_init; halt = i_halt; inst = i_inst;
    flag_we = i_fwe; flag_z = i_fz; flag_n = i_fn;
    lut_we = i_lwe; lut_addr = i_la; lut_wdata = i_lwd;
    e.be = e_be; e.sg = e_sg; e.off = e_off; e.sq = e_sq; e.cnt = e_cnt;
    @(posedge CLK);
    exp_q.push_back(e);
    #1;
  endtask

  // Quiet cycle: no branch, no writes, all pulse outputs expected low
  task automatic idle(input logic [3:0] e_cnt);
    cyc(0,0,NOP, 0,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,e_cnt);
  endtask

  // Monitor: compare registered outputs against the scoreboard mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (branch_en === e.be && bSIGN === e.sg && bOFFSET === e.off &&
            squash === e.sq && taken_cnt === e.cnt) begin
          n_pass++;
        end else begin
          $display("FAIL out#%0d: got be=%b sg=%b off=%h sq=%b cnt=%0d want be=%b sg=%b off=%h sq=%b cnt=%0d",
                   n_checks, branch_en, bSIGN, bOFFSET, squash, taken_cnt,
                   e.be, e.sg, e.off, e.sq, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int c;
    // Reset with random inputs (no LUT writes, so table state is known below)
    for (int i = 0; i < 2; i++)
      cyc(1, 1'($urandom), 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          0, 4'd0, 9'd0, 0,0,8'h00,0,4'd0);

    // Program the table
    cyc(0,0,NOP, 0,0,0, 1,4'd3,9'h105, 0,0,8'h00,0,4'd0);
    cyc(0,0,NOP, 0,0,0, 1,4'd2,9'h00A, 0,0,8'h00,0,4'd0);
    cyc(0,0,NOP, 0,0,0, 1,4'd1,9'h020, 0,0,8'h00,0,4'd0);
    cyc(0,0,NOP, 0,0,0, 1,4'd4,9'h1FF, 0,0,8'h00,0,4'd0);

    // Unconditional branch, backward 5
    cyc(0,0,B_U3, 0,0,0, 0,4'd0,9'd0, 1,1,8'h05,1,4'd1);
    idle(4'd1);

    // Z=1 then branch-if-Z taken; branch-if-!Z not taken
    cyc(0,0,NOP, 1,1,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd1);
    cyc(0,0,B_Z1, 0,0,0, 0,4'd0,9'd0, 1,0,8'h20,1,4'd2);
    idle(4'd2);
    cyc(0,0,B_NZ1, 0,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd2);

    // Flag write coincident with the branch: old Z=1 used, new Z=0 next
    cyc(0,0,B_NZ1, 1,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd2);
    cyc(0,0,B_NZ1, 0,0,0, 0,4'd0,9'd0, 1,0,8'h20,1,4'd3);
    idle(4'd3);

    // Branch-if-N: not taken with N=0, taken after N=1
    cyc(0,0,B_N4, 0,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd3);
    cyc(0,0,NOP, 1,0,1, 0,4'd0,9'd0, 0,0,8'h00,0,4'd3);
    cyc(0,0,B_N4, 0,0,0, 0,4'd0,9'd0, 1,1,8'hFF,1,4'd4);
    idle(4'd4);

    // Back-to-back taken branches: shadow one ignored
    cyc(0,0,B_U3, 0,0,0, 0,4'd0,9'd0, 1,1,8'h05,1,4'd5);
    cyc(0,0,B_U3, 0,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd5);
    idle(4'd5);

    // Halt with a taken branch: no pulse, stays halted until init
    cyc(0,1,B_U3, 0,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd5);
    cyc(0,0,B_U3, 0,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd5);
    cyc(1,0,NOP, 0,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd0);
    cyc(0,0,B_U3, 0,0,0, 0,4'd0,9'd0, 1,1,8'h05,1,4'd1);

    // Halt during the shadow cycle
    cyc(0,1,NOP, 0,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd1);
    cyc(0,0,B_U3, 0,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd1);
    cyc(1,0,NOP, 0,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd0);

    // Init mid-shadow: flag write dropped, LUT write kept
    cyc(0,0,B_U3, 0,0,0, 0,4'd0,9'd0, 1,1,8'h05,1,4'd1);
    cyc(1,0,B_U3, 1,1,0, 1,4'd5,9'h033, 0,0,8'h00,0,4'd0);
    cyc(0,0,B_Z1, 0,0,0, 0,4'd0,9'd0, 0,0,8'h00,0,4'd0);
    cyc(0,0,B_U5, 0,0,0, 0,4'd0,9'd0, 1,0,8'h33,1,4'd1);
    idle(4'd1);

    // Same-cycle LUT write and lookup at index 2: old entry, then new
    cyc(0,0,B_U2, 0,0,0, 1,4'd2,9'h1B0, 1,0,8'h0A,1,4'd2);
    idle(4'd2);
    cyc(0,0,B_U2, 0,0,0, 0,4'd0,9'd0, 1,1,8'hB0,1,4'd3);
    idle(4'd3);

    // Drive the counter into saturation and beyond
    c = 3;
    for (int i = 0; i < 14; i++) begin
      c = (c < 15) ? c + 1 : 15;
      cyc(0,0,B_U2, 0,0,0, 0,4'd0,9'd0, 1,1,8'hB0,1,4'(c));
      idle(4'(c));
    end

    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
